// File: rtl/instr_decode_pkg.sv
// -----------------------------------------------------------------------------
// instr_decode_pkg
// Shared definitions for the LEGv8 instruction-decode stage: opcode constants,
// the instruction-format code and the decoded control struct that travels
// through the stage's buffer registers alongside the immediate and PC.
// -----------------------------------------------------------------------------
package instr_decode_pkg;

  // 11-bit opcodes in instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // 8-bit opcodes in instr[31:24]
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;

  // 6-bit opcode in instr[31:26]
  localparam logic [5:0]  OP_B    = 6'h05;

  // 9-bit opcode in instr[31:23]
  localparam logic [8:0]  OP_MOVK = 9'h1E5;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_D   = 3'd1,
    FMT_CB  = 3'd2,
    FMT_B   = 3'd3,
    FMT_IW  = 3'd4,
    FMT_ILL = 3'd7
  } fmt_e;

  // Everything about a decoded instruction except the DATA_W-wide immediate
  // and PC, which depend on the stage parameter and are carried separately.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    fmt_e       fmt;
    logic [1:0] hw;
    logic       illegal;
  } dec_ctrl_t;

  function automatic logic is_r_op(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Purely combinational LEGv8 field decoder. Classifies a 32-bit instruction
// as R, D (LDUR/STUR), CB, B, IW (MOVK) or illegal, in that match priority,
// and produces register selects, write enable and the extended immediate.
//
// Ports:
//   instr  in   32      instruction word
//   ctrl   out  struct  selects, write enable, format, MOVK hw, illegal flag
//   imm    out  DATA_W  sign- or zero-extended immediate
// -----------------------------------------------------------------------------
module instr_field_decode
  import instr_decode_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]              instr,
  output dec_ctrl_t                ctrl,
  output logic signed [DATA_W-1:0] imm
);

  // Extension is by MSB replication only, never by arithmetic.
  function automatic logic signed [DATA_W-1:0] sext9(input logic [8:0] f);
    return {{(DATA_W-9){f[8]}}, f};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext19(input logic [18:0] f);
    return {{(DATA_W-19){f[18]}}, f};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext26(input logic [25:0] f);
    return {{(DATA_W-26){f[25]}}, f};
  endfunction

  function automatic logic signed [DATA_W-1:0] zext16(input logic [15:0] f);
    return {{(DATA_W-16){1'b0}}, f};
  endfunction

  always_comb begin
    ctrl         = '0;
    ctrl.fmt     = FMT_ILL;
    ctrl.illegal = 1'b1;
    imm          = '0;

    if (is_r_op(instr[31:21])) begin
      ctrl.fmt     = FMT_R;
      ctrl.illegal = 1'b0;
      ctrl.rs1     = instr[9:5];
      ctrl.rs2     = instr[20:16];
      ctrl.rd      = instr[4:0];
      ctrl.we      = 1'b1;
    end else if (instr[31:21] == OP_LDUR) begin
      ctrl.fmt     = FMT_D;
      ctrl.illegal = 1'b0;
      ctrl.rs1     = instr[9:5];
      ctrl.rd      = instr[4:0];
      ctrl.we      = 1'b1;
      imm          = sext9(instr[20:12]);
    end else if (instr[31:21] == OP_STUR) begin
      // Store data register (Rt) is read, not written, so it goes on rs2.
      ctrl.fmt     = FMT_D;
      ctrl.illegal = 1'b0;
      ctrl.rs1     = instr[9:5];
      ctrl.rs2     = instr[4:0];
      imm          = sext9(instr[20:12]);
    end else if ((instr[31:24] == OP_CBZ) || (instr[31:24] == OP_CBNZ)) begin
      ctrl.fmt     = FMT_CB;
      ctrl.illegal = 1'b0;
      ctrl.rs1     = instr[4:0];
      imm          = sext19(instr[23:5]);
    end else if (instr[31:26] == OP_B) begin
      ctrl.fmt     = FMT_B;
      ctrl.illegal = 1'b0;
      imm          = sext26(instr[25:0]);
    end else if (instr[31:23] == OP_MOVK) begin
      // MOVK keeps the other halfwords of Rd, so Rd is also a source.
      ctrl.fmt     = FMT_IW;
      ctrl.illegal = 1'b0;
      ctrl.rs1     = instr[4:0];
      ctrl.rd      = instr[4:0];
      ctrl.we      = 1'b1;
      ctrl.hw      = instr[22:21];
      imm          = zext16(instr[20:5]);
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
// Registered LEGv8 decode stage between fetch and register-file/ALU.
// Decodes combinationally ahead of the buffer, then holds the result in a
// main output register, optionally backed by a skid register so in_ready can
// be a flop. Counts emitted illegal instructions with a saturating counter.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                drop all buffered entries and any same-cycle accept
//   in_valid/in_ready    upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready  downstream handshake
//   out_rs1/rs2/rd/we    register-file selects and write enable
//   out_imm              extended immediate (DATA_W)
//   out_fmt/out_hw       format code, MOVK shift field
//   out_illegal          no opcode matched
//   out_pc               PC passthrough
//   illegal_cnt          saturating count of emitted illegal instructions
// -----------------------------------------------------------------------------
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic              out_we,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_fmt,
  output logic [1:0]        out_hw,
  output logic              out_illegal,
  output logic [DATA_W-1:0] out_pc,
  output logic [CNT_W-1:0]  illegal_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---- p0: combinational decode of the incoming instruction ----
  dec_ctrl_t                dec_ctrl_p0;
  logic signed [DATA_W-1:0] dec_imm_p0;

  instr_field_decode #(.DATA_W(DATA_W)) u_field_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl_p0),
    .imm   (dec_imm_p0)
  );

  // ---- p1: main output register and skid register ----
  logic                     vld_p1;
  dec_ctrl_t                ctrl_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        pc_p1;

  logic                     skid_vld_p1;
  dec_ctrl_t                skid_ctrl_p1;
  logic signed [DATA_W-1:0] skid_imm_p1;
  logic [DATA_W-1:0]        skid_pc_p1;

  logic ready_q;
  logic accept;
  logic emit;
  logic vld_next;
  logic skid_vld_next;
  logic load_main_new;
  logic load_main_skid;
  logic load_skid;

  // With the skid buffer, in_ready is registered; without it, the single
  // register may be refilled in the same cycle it is drained.
  assign in_ready = (SKID_EN != 0) ? ready_q : (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign emit     = vld_p1 && out_ready;

  always_comb begin
    vld_next       = vld_p1;
    skid_vld_next  = skid_vld_p1;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      vld_next      = 1'b0;
      skid_vld_next = 1'b0;
    end else if (!vld_p1) begin
      // The skid register is only ever occupied while main is, so an
      // empty main implies an empty skid.
      if (accept) begin
        vld_next      = 1'b1;
        load_main_new = 1'b1;
      end
    end else if (emit) begin
      if (skid_vld_p1) begin
        load_main_skid = 1'b1;
        skid_vld_next  = 1'b0;
      end else if (accept) begin
        load_main_new = 1'b1;
      end else begin
        vld_next = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry. Only reachable with SKID_EN,
      // since the combinational in_ready is low in this state otherwise.
      skid_vld_next = 1'b1;
      load_skid     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      ready_q     <= 1'b1;
      illegal_cnt <= '0;
    end else begin
      vld_p1      <= vld_next;
      skid_vld_p1 <= skid_vld_next;
      ready_q     <= !skid_vld_next;
      if (emit && ctrl_p1.illegal) begin
        illegal_cnt <= sat_inc(illegal_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_new) begin
      ctrl_p1 <= dec_ctrl_p0;
      imm_p1  <= dec_imm_p0;
      pc_p1   <= in_pc;
    end else if (load_main_skid) begin
      ctrl_p1 <= skid_ctrl_p1;
      imm_p1  <= skid_imm_p1;
      pc_p1   <= skid_pc_p1;
    end
    if (load_skid) begin
      skid_ctrl_p1 <= dec_ctrl_p0;
      skid_imm_p1  <= dec_imm_p0;
      skid_pc_p1   <= in_pc;
    end
  end

  // Payload registers are not reset; the outputs are forced to zero while
  // no entry is valid, which also gives all-zero outputs during reset.
  assign out_valid   = vld_p1;
  assign out_rs1     = vld_p1 ? ctrl_p1.rs1     : 5'd0;
  assign out_rs2     = vld_p1 ? ctrl_p1.rs2     : 5'd0;
  assign out_rd      = vld_p1 ? ctrl_p1.rd      : 5'd0;
  assign out_we      = vld_p1 ? ctrl_p1.we      : 1'b0;
  assign out_imm     = vld_p1 ? imm_p1          : '0;
  assign out_fmt     = vld_p1 ? ctrl_p1.fmt     : 3'd0;
  assign out_hw      = vld_p1 ? ctrl_p1.hw      : 2'd0;
  assign out_illegal = vld_p1 ? ctrl_p1.illegal : 1'b0;
  assign out_pc      = vld_p1 ? pc_p1           : '0;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = '0;
  logic [DATA_W-1:0] in_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic              out_we;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_fmt;
  logic [1:0]        out_hw;
  logic              out_illegal;
  logic [DATA_W-1:0] out_pc;
  logic [CNT_W-1:0]  illegal_cnt;

  instr_decode_stage #(.DATA_W(DATA_W), .SKID_EN(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_we(out_we),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_hw(out_hw),
    .out_illegal(out_illegal), .out_pc(out_pc), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [1:0]  hw;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we,
                              input logic [63:0] imm, input logic [2:0] fmt,
                              input logic [1:0] hw, input logic ill);
    exp_t e;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we;
    e.imm = imm; e.fmt = fmt; e.hw = hw; e.ill = ill; e.pc = '0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next rising edge whenever
  // out_valid && out_ready is seen here (inputs only change just after posedge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_emit: pc %0h emitted with nothing expected", out_pc);
      end else begin
        mon_e = sb.pop_front();
        if ({out_rs1, out_rs2, out_rd, out_we, out_imm, out_fmt, out_hw, out_illegal, out_pc} !==
            {mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.we, mon_e.imm, mon_e.fmt, mon_e.hw, mon_e.ill, mon_e.pc}) begin
          n_fail++;
          $display("FAIL emit pc=%0h: got rs1=%0d rs2=%0d rd=%0d we=%0d imm=%0h fmt=%0d hw=%0d ill=%0d pc=%0h expected rs1=%0d rs2=%0d rd=%0d we=%0d imm=%0h fmt=%0d hw=%0d ill=%0d pc=%0h",
                   mon_e.pc, out_rs1, out_rs2, out_rd, out_we, out_imm, out_fmt, out_hw, out_illegal, out_pc,
                   mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.we, mon_e.imm, mon_e.fmt, mon_e.hw, mon_e.ill, mon_e.pc);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] instr, input logic [63:0] pc,
                      input bit push, input exp_t e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 for instr %0h expected 1", instr);
    end else if (push) begin
      e.pc = pc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, sb.size(), 0);
  endtask

  // Hand-decoded expectations
  exp_t e_add, e_ldur, e_cbz, e_b, e_movk, e_stur, e_sub, e_ill;
  exp_t bp_e[4];
  logic [31:0] bp_i[4];
  logic [1:0]  sat_tbl[5];
  int idx, acc, bubbles, cyc;

  initial begin
    e_add  = mk(5'd1,  5'd2,  5'd3,  1'b1, 64'h0,                3'd0, 2'd0, 1'b0);
    e_ldur = mk(5'd6,  5'd0,  5'd5,  1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 2'd0, 1'b0);
    e_cbz  = mk(5'd9,  5'd0,  5'd0,  1'b0, 64'hFFFF_FFFF_FFFC_0000, 3'd2, 2'd0, 1'b0);
    e_b    = mk(5'd0,  5'd0,  5'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 2'd0, 1'b0);
    e_movk = mk(5'd7,  5'd0,  5'd7,  1'b1, 64'hBEEF,              3'd4, 2'd1, 1'b0);
    e_stur = mk(5'd4,  5'd2,  5'd0,  1'b0, 64'd16,                3'd1, 2'd0, 1'b0);
    e_sub  = mk(5'd11, 5'd12, 5'd10, 1'b1, 64'h0,                 3'd0, 2'd0, 1'b0);
    e_ill  = mk(5'd0,  5'd0,  5'd0,  1'b0, 64'h0,                 3'd7, 2'd0, 1'b1);

    bp_i[0] = 32'hAA030041; bp_e[0] = mk(5'd2, 5'd3, 5'd1, 1'b1, 64'h0,  3'd0, 2'd0, 1'b0); // ORR X1,X2,X3
    bp_i[1] = 32'h8A0600A4; bp_e[1] = mk(5'd5, 5'd6, 5'd4, 1'b1, 64'h0,  3'd0, 2'd0, 1'b0); // AND X4,X5,X6
    bp_i[2] = 32'hB5000043; bp_e[2] = mk(5'd3, 5'd0, 5'd0, 1'b0, 64'h2,  3'd2, 2'd0, 1'b0); // CBNZ X3,#2
    bp_i[3] = 32'h14000010; bp_e[3] = mk(5'd0, 5'd0, 5'd0, 1'b0, 64'h10, 3'd3, 2'd0, 1'b0); // B #16

    sat_tbl[0] = 2'd1; sat_tbl[1] = 2'd2; sat_tbl[2] = 2'd3; sat_tbl[3] = 2'd3; sat_tbl[4] = 2'd3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    check("rst_out_rd", out_rd, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Back-to-back decode of each format
    out_ready = 1'b1;
    send(32'h8B020023, 64'h1000, 1, e_add);
    check("latency_add", out_valid, 1);
    send(32'hF85F80C5, 64'h1004, 1, e_ldur);
    send(32'hB4800009, 64'h1008, 1, e_cbz);
    send(32'h17FFFFFF, 64'h100C, 1, e_b);
    send(32'hF2B7DDE7, 64'h1010, 1, e_movk);
    send(32'hF8010082, 64'h1014, 1, e_stur);
    send(32'hCB0C016A, 64'h1018, 1, e_sub);
    drain("drain_formats");

    // Backpressure: four offered with out_ready low, only two fit
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_instr = bp_i[idx];
      in_pc    = 64'h2000 + 64'(idx * 4);
      @(negedge clk);
      if (in_ready) begin
        bp_e[idx].pc = 64'h2000 + 64'(idx * 4);
        sb.push_back(bp_e[idx]);
        idx++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    bubbles = 0;
    cyc = 0;
    while ((idx < 4 || sb.size() != 0) && cyc < 50) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        in_instr = bp_i[idx];
        in_pc    = 64'h2000 + 64'(idx * 4);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!out_valid) bubbles++;
      if (idx < 4 && in_ready) begin
        bp_e[idx].pc = 64'h2000 + 64'(idx * 4);
        sb.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_no_bubble", bubbles, 0);
    check("bp_all_sent", idx, 4);
    check("bp_drained", sb.size(), 0);

    // Flush with main and skid both full
    out_ready = 1'b0;
    send(32'h00000000, 64'h3000, 0, e_ill);
    send(32'h8B020023, 64'h3004, 0, e_add);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_full_out_valid", out_valid, 0);
    check("flush_full_in_ready", in_ready, 1);

    // Flush with an illegal in main and a same-cycle accept attempt
    send(32'h00000000, 64'h3008, 0, e_ill);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hCB0C016A;
    in_pc    = 64'h300C;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_discard_accept", out_valid, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("flush_cnt_unchanged", illegal_cnt, 0);

    // Illegal instructions and counter saturation
    for (int k = 0; k < 5; k++) begin
      send(32'h00000000, 64'h4000 + 64'(k * 4), 1, e_ill);
      @(posedge clk);
      #1;
      check($sformatf("sat_cnt_%0d", k), illegal_cnt, sat_tbl[k]);
    end

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    send(bp_i[0], 64'h5000, 0, bp_e[0]);
    send(bp_i[1], 64'h5004, 0, bp_e[1]);
    check("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_cnt", illegal_cnt, 0);
    check("async_rst_out_pc", out_pc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h8B020023, 64'h6000, 1, e_add);
    check("post_rst_latency", out_valid, 1);
    drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
